// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared region map, requester indices and FSM/region encodings for mem_arbiter
package mem_arbiter_pkg;
    localparam logic [17:0] LOWMEM_BASE = 18'h00000;
    localparam logic [17:0] ROM_BASE    = 18'h02000;
    localparam logic [17:0] SPRAM_BASE  = 18'h20000;
    localparam int LOWMEM_BITS = 13;
    localparam int ROM_BITS    = 12;
    localparam int SPRAM_BITS  = 17;
    localparam int MON = 0;
    localparam int CPU = 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
    // Region code doubles as the bit position of its write strobe
    typedef enum logic [1:0] {REG_LOW, REG_ROM, REG_SPRAM, REG_NONE} region_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with registered last-winner
//   CLK, reset : clock, async active-high reset
//   en         : grants allowed this cycle
//   valid[1:0] : request lines
//   grant[1:0] : one-hot combinational grant
module rr_arb2 (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last;
    // On contention the requester that did not win last time goes first
    always_comb grant = !en ? 2'b00 : (&valid) ? (last ? 2'b01 : 2'b10) : valid;
    always_ff @(posedge CLK or posedge reset)
        if (reset) last <= 1'b1;
        else if (|grant) last <= grant[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the on-chip memory datapath between monitor and CPU
//   CLK, reset                : clock, async active-high reset
//   req_valid/write[1:0]      : per-requester request (bit 0 monitor, bit 1 CPU)
//   req_addr0/1, req_wdata0/1 : request address and write data
//   req_ready[1:0]            : accept pulse, combinational
//   rsp_valid[1:0], rsp_rdata : read response pulse and data
//   ram_addr, ram_wdata       : registered memory address/data
//   ram_we[2:0]               : registered one-hot write strobes for blocks 0..2
//   ram_rdata0/1/2            : block read data, one cycle after address
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int LOWMEM_WIDTH = LOWMEM_BITS,
    parameter int ROM_WIDTH    = ROM_BITS,
    parameter int SPRAM_WIDTH  = SPRAM_BITS
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [7:0]            req_wdata0,
    input  logic [7:0]            req_wdata1,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic [2:0]            ram_we,
    input  logic [7:0]            ram_rdata0,
    input  logic [7:0]            ram_rdata1,
    input  logic [7:0]            ram_rdata2
);
    state_t                state;
    region_t               region, dec;
    logic                  owner, wr, sel;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
    logic [2:0]            we_dec;

    // Reset gates the grant so ready stays low while reset is held
    rr_arb2 u_arb (
        .CLK   (CLK),
        .reset (reset),
        .en    (state == IDLE && !reset),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        sel    = grant[CPU];
        addr   = sel ? req_addr1 : req_addr0;
        wdata  = sel ? req_wdata1 : req_wdata0;
        dec    = ((addr >> LOWMEM_WIDTH) == ADDR_WIDTH'(LOWMEM_BASE >> LOWMEM_WIDTH)) ? REG_LOW :
                 ((addr >> ROM_WIDTH) == ADDR_WIDTH'(ROM_BASE >> ROM_WIDTH))          ? REG_ROM :
                 ((addr >> SPRAM_WIDTH) == ADDR_WIDTH'(SPRAM_BASE >> SPRAM_WIDTH))    ? REG_SPRAM : REG_NONE;
        we_dec = (req_write[sel] && dec != REG_NONE) ? (3'b001 << dec) : 3'b000;
    end

    // Block data arrives in RDWAIT, so the response is steered combinationally there
    always_comb begin
        rsp_valid = (state == RDWAIT) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        rsp_rdata = (state != RDWAIT)    ? 8'h00 :
                    (region == REG_LOW)   ? ram_rdata0 :
                    (region == REG_ROM)   ? ram_rdata1 :
                    (region == REG_SPRAM) ? ram_rdata2 : 8'h00;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            region    <= REG_NONE;
            owner     <= 1'b0;
            wr        <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    state     <= ISSUE;
                    ram_addr  <= addr;
                    ram_wdata <= wdata;
                    ram_we    <= we_dec;
                    region    <= dec;
                    owner     <= sel;
                    wr        <= req_write[sel];
                end
                ISSUE: begin
                    ram_we <= 3'b000;
                    state  <= wr ? IDLE : RDWAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with behavioural block memories
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0, req_write = '0;
    logic [17:0] req_addr0 = '0, req_addr1 = '0;
    logic [7:0]  req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata, ram_wdata;
    logic [17:0] ram_addr;
    logic [2:0]  ram_we;
    logic [7:0]  ram_rdata0, ram_rdata1, ram_rdata2;
    logic [7:0]  mem0 [8192];
    logic [7:0]  mem1 [4096];
    logic [7:0]  mem2 [131072];
    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .CLK        (CLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata0 (ram_rdata0),
        .ram_rdata1 (ram_rdata1),
        .ram_rdata2 (ram_rdata2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_we[0]) mem0[ram_addr[12:0]] <= ram_wdata;
        if (ram_we[1]) mem1[ram_addr[11:0]] <= ram_wdata;
        if (ram_we[2]) mem2[ram_addr[16:0]] <= ram_wdata;
        ram_rdata0 <= mem0[ram_addr[12:0]];
        ram_rdata1 <= mem1[ram_addr[11:0]];
        ram_rdata2 <= mem2[ram_addr[16:0]];
    end

    task automatic cyc;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 2'b11;
        repeat (2) cyc();
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=00", rsp_rdata); end
        checks++; if (ram_addr !== 18'h0) begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
        checks++; if (ram_wdata !== 8'h00) begin failures++; $display("FAIL rst_ram_wdata got=%h exp=00", ram_wdata); end
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL rst_ram_we got=%b exp=000", ram_we); end
        req_valid = 2'b00;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_mon_write_read;
        req_valid = 2'b01; req_write = 2'b01; req_addr0 = 18'h00010; req_wdata0 = 8'hA5;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mw_ready got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00; req_write = 2'b00;
        #1;
        checks++; if (ram_we !== 3'b001) begin failures++; $display("FAIL mw_we got=%b exp=001", ram_we); end
        checks++; if (ram_addr !== 18'h00010) begin failures++; $display("FAIL mw_addr got=%h exp=00010", ram_addr); end
        checks++; if (ram_wdata !== 8'hA5) begin failures++; $display("FAIL mw_wdata got=%h exp=a5", ram_wdata); end
        cyc();
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL mw_we_clear got=%b exp=000", ram_we); end
        checks++; if (ram_addr !== 18'h00010) begin failures++; $display("FAIL mw_addr_hold got=%h exp=00010", ram_addr); end
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mr_ready got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mr_rsp_early got=%b exp=00", rsp_valid); end
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL mr_we got=%b exp=000", ram_we); end
        cyc();
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL mr_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_rdata !== 8'hA5) begin failures++; $display("FAIL mr_rdata got=%h exp=a5", rsp_rdata); end
        cyc();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mr_rsp_pulse got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_cpu_reads;
        req_valid = 2'b10; req_write = 2'b00; req_addr1 = 18'h02000;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL cr1_ready got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL cr1_we got=%b exp=000", ram_we); end
        checks++; if (ram_addr !== 18'h02000) begin failures++; $display("FAIL cr1_addr got=%h exp=02000", ram_addr); end
        cyc();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL cr1_rsp_valid got=%b exp=10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h3C) begin failures++; $display("FAIL cr1_rdata got=%h exp=3c", rsp_rdata); end
        cyc();
        req_valid = 2'b10; req_addr1 = 18'h20004;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL cr2_ready got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL cr2_we got=%b exp=000", ram_we); end
        cyc();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL cr2_rsp_valid got=%b exp=10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h77) begin failures++; $display("FAIL cr2_rdata got=%h exp=77", rsp_rdata); end
        cyc();
    endtask

    task automatic test_unmapped;
        req_valid = 2'b10; req_write = 2'b10; req_addr1 = 18'h05000; req_wdata1 = 8'h55;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL uw_ready got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00; req_write = 2'b00;
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL uw_we got=%b exp=000", ram_we); end
        cyc();
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL uw_we_after got=%b exp=000", ram_we); end
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL ur_ready got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL ur_we got=%b exp=000", ram_we); end
        cyc();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL ur_rsp_valid got=%b exp=10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL ur_rdata got=%h exp=00", rsp_rdata); end
        cyc();
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        reset = 1'b1;
        cyc();
        req_valid = 2'b11; req_write = 2'b00; req_addr0 = 18'h00010; req_addr1 = 18'h20004;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (k % 2 == 1) ? 8'h77 : 8'hA5;
            checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL alt_ready[%0d] got=%b exp=%b", k, req_ready, exp_g); end
            cyc();
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL alt_issue_ready[%0d] got=%b exp=00", k, req_ready); end
            cyc();
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL alt_wait_ready[%0d] got=%b exp=00", k, req_ready); end
            checks++; if (rsp_valid !== exp_g) begin failures++; $display("FAIL alt_rsp_valid[%0d] got=%b exp=%b", k, rsp_valid, exp_g); end
            checks++; if (rsp_rdata !== exp_d) begin failures++; $display("FAIL alt_rdata[%0d] got=%h exp=%h", k, rsp_rdata, exp_d); end
            cyc();
        end
        req_valid = 2'b00;
        cyc();
    endtask

    task automatic test_rdwait_hold;
        req_valid = 2'b01; req_write = 2'b00; req_addr0 = 18'h00010;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rh_ready got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        req_valid = 2'b10; req_addr1 = 18'h02000;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rh_withheld got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rh_rsp_valid got=%b exp=01", rsp_valid); end
        cyc();
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rh_accept got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL rh_rsp2_valid got=%b exp=10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h3C) begin failures++; $display("FAIL rh_rdata got=%h exp=3c", rsp_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid_write;
        req_valid = 2'b01; req_write = 2'b01; req_addr0 = 18'h20000; req_wdata0 = 8'h99;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rm_ready got=%b exp=01", req_ready); end
        cyc();
        reset = 1'b1;
        req_valid = 2'b00; req_write = 2'b00;
        #1;
        checks++; if (ram_we !== 3'b000) begin failures++; $display("FAIL rm_we got=%b exp=000", ram_we); end
        checks++; if (ram_addr !== 18'h0) begin failures++; $display("FAIL rm_addr got=%h exp=0", ram_addr); end
        checks++; if (ram_wdata !== 8'h00) begin failures++; $display("FAIL rm_wdata got=%h exp=00", ram_wdata); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rm_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rm_ready_rst got=%b exp=00", req_ready); end
        cyc();
        reset = 1'b0;
        req_valid = 2'b10; req_addr1 = 18'h20000;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rm_first_accept got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL rm_rsp2_valid got=%b exp=10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h11) begin failures++; $display("FAIL rm_unwritten got=%h exp=11", rsp_rdata); end
        cyc();
    endtask

    initial begin
        mem1[0] = 8'h3C;
        mem2[0] = 8'h11;
        mem2[4] = 8'h77;
        test_reset();
        test_mon_write_read();
        test_cpu_reads();
        test_unmapped();
        test_alternate();
        test_rdwait_hold();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
